ioctl_mem_arbiter: RTL and testbench

//  Sits between the SPI download engine (ioctl_* word stream) and the single system memory port.

---
 rtl/ioctl_mem_arbiter_if.sv | 53 +++++
 rtl/ioctl_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ioctl_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_mem_arbiter_if.sv
// ioctl_mem_arbiter_if: download stream, CPU port and memory port
// master = arbiter side; slave = downloader/CPU/memory side.
// dl_checksum exists only when DL_CHECKSUM_EN is defined.
interface ioctl_mem_arbiter_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ack;
  logic        dl_done;
  logic        dl_overflow;
`ifdef DL_CHECKSUM_EN
  logic [15:0] dl_checksum;
`endif

  modport master (
    input  ioctl_download, ioctl_wr,
    input  ioctl_addr, ioctl_dout,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  mem_dout, mem_ack,
    output ioctl_wait, cpu_dout, cpu_ack,
    output mem_req, mem_we, mem_addr, mem_din,
    output dl_done, dl_overflow
`ifdef DL_CHECKSUM_EN
    , output dl_checksum
`endif
  );

  modport slave (
    output ioctl_download, ioctl_wr,
    output ioctl_addr, ioctl_dout,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output mem_dout, mem_ack,
    input  ioctl_wait, cpu_dout, cpu_ack,
    input  mem_req, mem_we, mem_addr, mem_din,
    input  dl_done, dl_overflow
`ifdef DL_CHECKSUM_EN
    , input dl_checksum
`endif
  );
endinterface

// File: rtl/ioctl_mem_arbiter.sv
// ioctl_mem_arbiter: buffers download words and shares one memory
// port between the downloader (priority) and the CPU (burst guard).
// Ports: clk_sys, reset (sync, active-high), bus (master modport:
// ioctl_*, cpu_*, mem_*, dl_done, dl_overflow).
// Optional: DL_CHECKSUM_EN adds dl_checksum (sum of written words).
module ioctl_mem_arbiter #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          MAX_DL_BURST = 8,
  parameter logic [24:0] DL_BASE      = 25'h0
) (
  input logic                 clk_sys,
  input logic                 reset,
  ioctl_mem_arbiter_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_DL_BURST + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DL   = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;

  logic [40:0]   fifo_q [FIFO_DEPTH];
  logic [40:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          full, empty, push, pop;
  logic [1:0]    state;
  logic [BW-1:0] burst;
  logic          grant_dl, grant_cpu;
  logic          in_dl, in_cpu;
  logic [15:0]   cpu_dout_q;
  logic          wait_q, ovf_q;
  logic          dl_prev, dl_active;
  logic          dl_rise, done_cond;

  assign full  = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign push  = bus.ioctl_wr && !full;
  assign pop   = in_dl && bus.mem_ack;
  assign head  = fifo_q[rd_ptr];

  always_comb begin
    count_nx = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      fifo_q[wr_ptr] <= {DL_BASE + bus.ioctl_addr,
                         bus.ioctl_dout};
  end

  // wait is computed from the next count so it tracks
  // the occupancy the downloader sees one cycle later
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wait_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nx;
      wait_q <= count_nx >= CW'(FIFO_DEPTH - 1);
    end
  end

  assign in_dl  = state == S_DL;
  assign in_cpu = state == S_CPU;

  assign grant_dl = state == S_IDLE && !empty &&
    (!bus.cpu_req || burst < BW'(MAX_DL_BURST));
  assign grant_cpu = state == S_IDLE && !grant_dl &&
    bus.cpu_req;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      cpu_dout_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_dl)       state <= S_DL;
          else if (grant_cpu) state <= S_CPU;
        end
        S_DL: begin
          if (bus.mem_ack) state <= S_IDLE;
        end
        S_CPU: begin
          if (bus.mem_ack) begin
            state      <= S_IDLE;
            cpu_dout_q <= bus.mem_dout;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // burst counts download grants only while the CPU waits
  always_ff @(posedge clk_sys) begin
    if (reset)
      burst <= '0;
    else if (!bus.cpu_req || grant_cpu)
      burst <= '0;
    else if (grant_dl)
      burst <= burst + BW'(1);
  end

  assign bus.mem_req  = in_dl || in_cpu;
  assign bus.mem_we   = in_dl || (in_cpu && bus.cpu_we);
  assign bus.mem_addr = in_dl  ? head[40:16] :
                        in_cpu ? bus.cpu_addr : '0;
  assign bus.mem_din  = in_dl  ? head[15:0] :
                        in_cpu ? bus.cpu_din : '0;
  assign bus.cpu_ack  = in_cpu && bus.mem_ack;
  assign bus.cpu_dout = bus.cpu_ack ? bus.mem_dout
                                    : cpu_dout_q;
  assign bus.ioctl_wait = wait_q;

  assign dl_rise   = bus.ioctl_download && !dl_prev;
  assign done_cond = dl_active && !bus.ioctl_download &&
                     empty && state == S_IDLE;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev   <= 1'b0;
      dl_active <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      dl_prev <= bus.ioctl_download;
      if (bus.ioctl_download) dl_active <= 1'b1;
      else if (done_cond)     dl_active <= 1'b0;
      if (bus.ioctl_wr && full) ovf_q <= 1'b1;
      else if (dl_rise)         ovf_q <= 1'b0;
    end
  end

  assign bus.dl_done     = done_cond;
  assign bus.dl_overflow = ovf_q;

`ifdef DL_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk_sys) begin
    if (reset || dl_rise)
      csum_q <= '0;
    else if (pop && (dl_active || bus.ioctl_download))
      csum_q <= csum_q + head[15:0];
  end

  assign bus.dl_checksum = csum_q;
`endif
endmodule

// File: tb/tb_ioctl_mem_arbiter.sv
// tb_ioctl_mem_arbiter: directed + random checks of the arbiter
// against a queue-based model and a behavioural memory.
module tb_ioctl_mem_arbiter;
  localparam int          DEPTH = 4;
  localparam int          MAXB  = 8;
  localparam logic [24:0] BASE  = 25'h0100000;

  typedef struct packed {
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
  } txn_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  ioctl_mem_arbiter_if bus ();

  ioctl_mem_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .MAX_DL_BURST(MAXB),
    .DL_BASE     (BASE)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  txn_t        log_q [$];
  txn_t        exp_q [$];
  logic [15:0] mem_model [logic [24:0]];
  int          log_base = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          ack_dly  = 2;
  bit          hold     = 1'b0;
  int          stray_req = 0;
  logic [15:0] exp_sum  = '0;

  // memory: acks ack_dly cycles after seeing mem_req
  int   rcnt = 0;
  int   stray_seen = 0;
  txn_t rt;
  always @(posedge clk_sys) begin
    #1;
    bus.mem_ack = 1'b0;
    if (stray_req != stray_seen) begin
      stray_seen   = stray_req;
      bus.mem_ack  = 1'b1;
      bus.mem_dout = 16'hBAD0;
    end else if (reset || !bus.mem_req || hold) begin
      rcnt = 0;
    end else if (rcnt >= ack_dly) begin
      rt.we   = bus.mem_we;
      rt.addr = bus.mem_addr;
      rt.data = bus.mem_din;
      if (bus.mem_we) begin
        mem_model[bus.mem_addr] = bus.mem_din;
        bus.mem_dout = $urandom;
      end else if (mem_model.exists(bus.mem_addr)) begin
        bus.mem_dout = mem_model[bus.mem_addr];
      end else begin
        bus.mem_dout = 16'hDEAD;
      end
      log_q.push_back(rt);
      bus.mem_ack = 1'b1;
      rcnt = 0;
    end else begin
      rcnt++;
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] dl_addr(
      input logic [24:0] a);
    int s;
    s = (int'(BASE) + int'(a)) % 33554432;
    return s[24:0];
  endfunction

  // drive one strobe cycle (or idle) and record the model entry
  task automatic drive(input bit en, input logic [24:0] a,
                       input logic [15:0] d, input bit acc);
    txn_t t;
    bus.ioctl_wr   = en;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (en && acc) begin
      t.we   = 1'b1;
      t.addr = dl_addr(a);
      t.data = d;
      exp_q.push_back(t);
      exp_sum = exp_sum + d;
    end
  endtask

  task automatic dl_start();
    bus.ioctl_download = 1'b1;
    exp_sum = '0;
  endtask

  task automatic wait_log(input string tag);
    int c = 0;
    while (log_q.size() - log_base < exp_q.size()
           && c < 400) begin
      tick();
      c++;
    end
    chk({tag, "_logcnt"}, log_q.size() - log_base,
        exp_q.size());
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_n"}, log_q.size() - log_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_txn%0d", tag, i),
          log_q[log_base + i], exp_q[i]);
    log_base = log_q.size();
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!bus.dl_done && c < 100) begin
      tick();
      c++;
    end
    chk({tag, "_done"}, bus.dl_done, 1);
`ifdef DL_CHECKSUM_EN
    chk({tag, "_csum"}, bus.dl_checksum, exp_sum);
`endif
    tick();
    chk({tag, "_donepulse"}, bus.dl_done, 0);
`ifdef DL_CHECKSUM_EN
    tick();
    chk({tag, "_csumfrz"}, bus.dl_checksum, exp_sum);
`endif
  endtask

  initial begin
    int   sent, cyc, c;
    bit   wait_d, en;
    int   ra;
    txn_t t;

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr   = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_din    = '0;
    repeat (3) tick();

    // reset state
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_wait", bus.ioctl_wait, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_cpu_dout", bus.cpu_dout, 0);
    chk("rst_done", bus.dl_done, 0);
    chk("rst_ovf", bus.dl_overflow, 0);
    reset = 1'b0;
    tick();

    // four words, FIFO fills, wait at count 3
    hold = 1'b1;
    ack_dly = 2;
    dl_start();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 25'(2 * i), 16'(32'h1111 * (i + 1)), 1'b1);
      tick();
      chk($sformatf("t1_wait%0d", i), bus.ioctl_wait,
          (i + 1) >= DEPTH - 1);
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_head_addr", bus.mem_addr, BASE);
    chk("t1_head_din", bus.mem_din, 16'h1111);
    chk("t1_ovf", bus.dl_overflow, 0);
    hold = 1'b0;
    bus.ioctl_download = 1'b0;
    wait_log("t1");
    wait_done("t1");
    compare_log("t1");

    // random stream with delayed wait sampling, ack held off
    dl_start();
    hold = 1'b1;
    sent = 0;
    cyc = 0;
    wait_d = 1'b0;
    while (sent < 24 && cyc < 600) begin
      if (cyc == 39) begin
        chk("t2_fill", (sent >= DEPTH - 1) && (sent <= DEPTH), 1);
        chk("t2_ovf_hold", bus.dl_overflow, 0);
      end
      if (cyc == 40) hold = 1'b0;
      en = !wait_d && ($urandom_range(0, 3) != 0);
      ra = (sent == 5) ? 32'h1FFFFFE
                       : 32'h1000 + 2 * $urandom_range(0, 4095);
      drive(en, ra[24:0], 16'($urandom), 1'b1);
      if (en) sent++;
      wait_d = bus.ioctl_wait;
      ack_dly = $urandom_range(0, 3);
      tick();
      cyc++;
    end
    drive(1'b0, '0, '0, 1'b0);
    bus.ioctl_download = 1'b0;
    wait_log("t2");
    wait_done("t2");
    chk("t2_ovf", bus.dl_overflow, 0);
    compare_log("t2");

    // fifth word into a full FIFO is dropped
    dl_start();
    hold = 1'b1;
    ack_dly = 1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 25'(32'h100 + 2 * i), 16'($urandom), i < 4);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("t3_ovf_set", bus.dl_overflow, 1);
    hold = 1'b0;
    wait_log("t3");
    chk("t3_ovf_sticky", bus.dl_overflow, 1);
    bus.ioctl_download = 1'b0;
    wait_done("t3");
    chk("t3_ovf_after", bus.dl_overflow, 1);
    compare_log("t3");
    tick();
    dl_start();
    tick();
    tick();
    chk("t3_ovf_clr", bus.dl_overflow, 0);

    // download burst vs held CPU read
    hold = 1'b1;
    ack_dly = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 25'(32'h200 + 2 * k), 16'($urandom), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = BASE + 25'd2;
    bus.cpu_din  = 16'h5A5A;
    hold = 1'b0;
    wait_d = bus.ioctl_wait;
    c = 0;
    while (!bus.cpu_ack && c < 300) begin
      en = !wait_d;
      drive(en, 25'(32'h200 + 2 * (c + 3)),
            16'($urandom), 1'b1);
      wait_d = bus.ioctl_wait;
      tick();
      c++;
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("t4_cpu_ack", bus.cpu_ack, 1);
    chk("t4_cpu_dout", bus.cpu_dout, 16'h2222);
    chk("t4_burst_pos", log_q.size() - log_base - 1, 1 + MAXB);
    t.we = 1'b0;
    t.addr = BASE + 25'd2;
    t.data = 16'h5A5A;
    exp_q.insert(1 + MAXB, t);
    bus.cpu_req = 1'b0;
    bus.ioctl_download = 1'b0;
    wait_log("t4");
    wait_done("t4");
    chk("t4_ovf", bus.dl_overflow, 0);
    compare_log("t4");

    // CPU write outside download, one-cycle grant latency
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 25'h0ABCDE;
    bus.cpu_din  = 16'($urandom);
    bus.cpu_req  = 1'b1;
    tick();
    chk("t4w_mem_req", bus.mem_req, 1);
    chk("t4w_mem_we", bus.mem_we, 1);
    chk("t4w_mem_addr", bus.mem_addr, 25'h0ABCDE);
    chk("t4w_mem_din", bus.mem_din, bus.cpu_din);
    c = 0;
    while (!bus.cpu_ack && c < 20) begin
      tick();
      c++;
    end
    chk("t4w_ack", bus.cpu_ack, 1);
    t.we = 1'b1;
    t.addr = 25'h0ABCDE;
    t.data = bus.cpu_din;
    exp_q.push_back(t);
    bus.cpu_req = 1'b0;
    tick();
    chk("t4w_idle", bus.mem_req, 0);
    compare_log("t4w");

    // reset in the middle of a download write
    dl_start();
    hold = 1'b1;
    drive(1'b1, 25'h280, 16'h7777, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("t5_req_before", bus.mem_req, 1);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    chk("t5_req_drop", bus.mem_req, 0);
    chk("t5_wait", bus.ioctl_wait, 0);
    reset = 1'b0;
    hold = 1'b0;
    stray_req++;
    tick();
    tick();
    chk("t5_req_idle", bus.mem_req, 0);
    chk("t5_cpu_ack", bus.cpu_ack, 0);
    chk("t5_cpu_dout", bus.cpu_dout, 0);
    tick();
    chk("t5_no_write", log_q.size() - log_base, 0);
    chk("t5_done", bus.dl_done, 0);

    // checksum wrap case
    dl_start();
    ack_dly = 1;
    tick();
    drive(1'b1, 25'h300, 16'hFFFF, 1'b1);
    tick();
    drive(1'b1, 25'h302, 16'h0002, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    bus.ioctl_download = 1'b0;
    chk("t6_sum_model", exp_sum, 16'h0001);
    wait_log("t6");
    wait_done("t6");
    compare_log("t6");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
